pkt_sfifo: RTL and testbench
============================

# pkt_sfifo

Single-clock, parametrised packet FIFO for the Ethernet datapath, built on the same width/depth conventions as our dual-clock FIFO. Adds packet semantics on the write side: words stay invisible to the reader until `wr_commit`; `wr_abort` or an overflow rewinds the partial packet. It also adds first-word-fall-through mode, programmable almost-full, fill level and drop statistics. It sits between the MAC receive path and frame consumers, so that truncated or bad frames never reach the reader.

## Interface
- `DATA_WIDTH`, 18: word width; 16 data bits plus 2 control bits in the standard datapath.
- `ADDRESS_WIDTH`, 13: depth = 2^ADDRESS_WIDTH words.
- `ALMOST_FULL_TH`, 2^ADDRESS_WIDTH-64: `almost_full` asserts when free words ≤ (2^ADDRESS_WIDTH − ALMOST_FULL_TH).
- `FWFT`, 0: 0 = registered read, data one cycle after `rd_en`; 1 = head word presented on `dout` whenever `empty`=0.
- `clk` in 1: single clock; one clock, all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `din` in DATA_WIDTH: write data.
- `wr_en` in 1: write `din` into the current packet.
- `wr_commit` in 1: end of packet; publish it to the reader (the word on `din` is included if `wr_en`=1 in the same cycle).
- `wr_abort` in 1: discard the current uncommitted packet.
- `full` out 1: no free word relative to the shadow write pointer.
- `almost_full` out 1: see `ALMOST_FULL_TH`.
- `rd_en` in 1: pop one committed word.
- `dout` out DATA_WIDTH: read data.
- `empty` out 1: no committed unread word.
- `rd_count` out ADDRESS_WIDTH+1: committed unread words, 0..2^ADDRESS_WIDTH.
- `drop_cnt` out 16: packets dropped by overflow; saturates at 0xFFFF.
- `overflow` out 1: one-cycle pulse on the first rejected write of a packet.

## Operation
- Pointers are ADDRESS_WIDTH+1 bits, with the MSB used as the wrap bit: `wptr_shadow`, `wptr_commit`, `rptr`.
- `full` = (`wptr_shadow` − `rptr`) == 2^ADDRESS_WIDTH.
- `empty` = (`wptr_commit` == `rptr`), with `FWFT`=0.
- `rd_count` = `wptr_commit` − `rptr`.
- Write FSM states:
  - IDLE → IN_PKT on `wr_en`.
  - IN_PKT → IDLE on commit or abort.
  - IN_PKT or IDLE → DROPPING on `wr_en`&&`full`.
  - DROPPING → IDLE on `wr_commit` or `wr_abort`.
- Commit, outside DROPPING: `wptr_commit` ← `wptr_shadow` (+1 if `wr_en`). A commit with no words written is a no-op.
- Abort: `wptr_shadow` ← `wptr_commit`.
- DROPPING:
  - all `wr_en` are ignored;
  - on exit, `wptr_shadow` ← `wptr_commit` and `drop_cnt`++ (saturating).
  - `overflow` pulses only on the IN_PKT/IDLE→DROPPING edge.
- Simultaneous `wr_commit` and `wr_abort`: abort wins.
- Write while `full` is rejected even if `rd_en` frees a word in the same cycle; `full` is evaluated on pre-edge pointers.
- `rd_en` while `empty`: ignored, no pointer change, `dout` holds.
- Simultaneous `rd_en` and `wr_en`/commit: all legal; pointers update independently.
- `FWFT`=1: an internal output register is prefetched from RAM.
  - `empty` deasserts once the head word is loaded into `dout`.
  - `rd_en` advances to the next word, or asserts `empty`.
- Reset (async, any state): all pointers 0, FSM IDLE, `dout`=0, `empty`=1, `full`=0, `almost_full`=0, `rd_count`=0, `drop_cnt`=0, `overflow`=0.
- Any in-flight packet and all stored data are lost on reset.

## Timing
- Write to RAM: same edge as `wr_en`.
- Commit to reader visibility:
  - `FWFT`=0: `empty`/`rd_count` update the cycle after the commit edge.
  - `FWFT`=1: `empty` deasserts 2 cycles after the commit edge, to allow the RAM read plus output register.
- Read latency (`FWFT`=0): `dout` valid on the edge following `rd_en`&&!`empty`, and held until the next pop.
- `full`, `almost_full`, `rd_count`: registered, updated on the edge following the causing write, commit, abort or read.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Package `pkt_fifo_pkg`:
  - write-FSM state encoding (IDLE, IN_PKT, DROPPING);
  - pointer-width helper constant (ADDRESS_WIDTH+1);
  - `DROP_CNT_WIDTH`=16.
- Sub-module `sfifo_ram`: simple dual-port RAM, one write port and one read port, registered read, parametrised by DATA_WIDTH/ADDRESS_WIDTH; infers block RAM.
- Top contains pointers, write FSM, flag logic and the FWFT prefetch register.

## Test plan
All scenarios use DATA_WIDTH=18, ADDRESS_WIDTH=4 (16 words), ALMOST_FULL_TH=12.
- Write 5 words 0x00001–0x00005 with `wr_commit` on the last → `empty`=1 until the cycle after commit, then `rd_count`=5. Reads (`FWFT`=0) return 0x00001–0x00005, each one cycle after its `rd_en`.
- Write 3 words, assert `wr_abort`, then write and commit 2 words 0x0AA/0x0BB → `rd_count`=2; reads return 0x0AA, 0x0BB only.
- Write 17 words with no reads, commit on the 17th → `full`=1 after the 16th, `overflow` pulses once at the 17th, `drop_cnt`=1, `rd_count`=0, `empty`=1.
- Commit a 10-word packet, then stream 16-word packets with continuous `rd_en` across pointer wrap → all data in order, no spurious `full`/`empty`, `almost_full` asserts exactly at 12 words occupied.
- `FWFT`=1, commit 1 word 0x3FFFF → `dout`=0x3FFFF and `empty`=0 two cycles after commit; `rd_en` → `empty`=1 next cycle.
- Assert `rst_n`=0 mid-packet with 4 committed words → all outputs reach their reset values immediately, asynchronously; after release the FIFO is empty and a fresh packet passes intact.

Source files
------------

// File: rtl/pkt_fifo_pkg.sv
// Shared types, constants and helpers for the single-clock packet FIFO.
package pkt_fifo_pkg;

  localparam int unsigned DROP_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StInPkt    = 2'd1,
    StDropping = 2'd2
  } wr_state_e;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + DROP_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module sfifo_ram #(
  parameter int unsigned DATA_WIDTH    = 18,
  parameter int unsigned ADDRESS_WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDRESS_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds its value between reads so the FIFO output stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/pkt_sfifo.sv
// Single-clock packet FIFO: writes stay hidden until committed; aborts and
// overflows rewind the partial packet. Optional first-word-fall-through output.
module pkt_sfifo
  import pkt_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 18,
  parameter int unsigned ADDRESS_WIDTH  = 13,
  parameter int unsigned ALMOST_FULL_TH = (1 << ADDRESS_WIDTH) - 64,
  parameter bit          FWFT           = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      wr_en,
  input  logic                      wr_commit,
  input  logic                      wr_abort,
  output logic                      full,
  output logic                      almost_full,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      empty,
  output logic [ADDRESS_WIDTH:0]    rd_count,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      overflow
);

  localparam int unsigned   PW     = ptr_width(ADDRESS_WIDTH);
  localparam logic [PW-1:0] DepthP = PW'(2**ADDRESS_WIDTH);
  localparam logic [PW-1:0] AfThP  = PW'(ALMOST_FULL_TH);

  wr_state_e state_q, state_d;

  logic [PW-1:0] wshadow_q, wshadow_d;
  logic [PW-1:0] wcommit_q, wcommit_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] fptr_q, fptr_d;
  logic [PW-1:0] occ_d;
  logic [PW-1:0] rd_count_q;

  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic                      overflow_q, overflow_d;
  logic                      full_q, almost_full_q, empty_q;

  logic                     ram_we, ram_re;
  logic [ADDRESS_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0]    ram_rdata;

  logic                  ram_vld_q, ram_vld_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] dout_q;

  logic end_pkt, pop, move, fetch;

  sfifo_ram #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (ram_we),
    .waddr(wshadow_q[ADDRESS_WIDTH-1:0]),
    .wdata(din),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Write FSM and shadow/commit pointers. full_q reflects pre-edge pointers, so
  // a same-cycle read never rescues a write that meets a full FIFO.
  always_comb begin
    state_d    = state_q;
    wshadow_d  = wshadow_q;
    wcommit_d  = wcommit_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = 1'b0;
    ram_we     = 1'b0;
    end_pkt    = wr_commit || wr_abort;

    case (state_q)
      StIdle, StInPkt: begin
        if (wr_en && full_q) begin
          overflow_d = 1'b1;
          if (end_pkt) begin
            // Rejected word was also the packet end: drop it in one cycle.
            wshadow_d  = wcommit_q;
            drop_cnt_d = sat_inc(drop_cnt_q);
            state_d    = StIdle;
          end else begin
            state_d = StDropping;
          end
        end else begin
          ram_we = wr_en;
          if (wr_abort) begin
            wshadow_d = wcommit_q;
            state_d   = StIdle;
          end else if (wr_commit) begin
            wshadow_d = wshadow_q + {{(PW-1){1'b0}}, wr_en};
            wcommit_d = wshadow_q + {{(PW-1){1'b0}}, wr_en};
            state_d   = StIdle;
          end else if (wr_en) begin
            wshadow_d = wshadow_q + {{(PW-1){1'b0}}, 1'b1};
            state_d   = StInPkt;
          end
        end
      end
      StDropping: begin
        if (end_pkt) begin
          wshadow_d  = wcommit_q;
          drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read side. In FWFT mode fptr runs ahead of rptr, filling the RAM read
  // register and then the output register; rptr only moves on a consumer pop.
  always_comb begin
    if (FWFT) begin
      pop = rd_en && out_vld_q;
    end else begin
      pop = rd_en && !empty_q;
    end
    move  = FWFT && ram_vld_q && (!out_vld_q || pop);
    fetch = FWFT && (fptr_q != wcommit_q) && (!ram_vld_q || move);

    rptr_d = rptr_q + {{(PW-1){1'b0}}, pop};
    fptr_d = fptr_q + {{(PW-1){1'b0}}, fetch};

    ram_vld_d = ram_vld_q;
    if (fetch) begin
      ram_vld_d = 1'b1;
    end else if (move) begin
      ram_vld_d = 1'b0;
    end

    out_vld_d = out_vld_q;
    if (move) begin
      out_vld_d = 1'b1;
    end else if (FWFT && pop) begin
      out_vld_d = 1'b0;
    end

    ram_re    = FWFT ? fetch : pop;
    ram_raddr = FWFT ? fptr_q[ADDRESS_WIDTH-1:0] : rptr_q[ADDRESS_WIDTH-1:0];
    occ_d     = wshadow_d - rptr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wshadow_q     <= '0;
      wcommit_q     <= '0;
      rptr_q        <= '0;
      fptr_q        <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      empty_q       <= 1'b1;
      rd_count_q    <= '0;
      ram_vld_q     <= 1'b0;
      out_vld_q     <= 1'b0;
      dout_q        <= '0;
    end else begin
      state_q       <= state_d;
      wshadow_q     <= wshadow_d;
      wcommit_q     <= wcommit_d;
      rptr_q        <= rptr_d;
      fptr_q        <= fptr_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
      full_q        <= (occ_d == DepthP);
      almost_full_q <= (occ_d >= AfThP);
      empty_q       <= FWFT ? !out_vld_d : (wcommit_d == rptr_d);
      rd_count_q    <= wcommit_d - rptr_d;
      ram_vld_q     <= ram_vld_d;
      out_vld_q     <= out_vld_d;
      if (move) begin
        dout_q <= ram_rdata;
      end
    end
  end

  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign empty       = empty_q;
  assign rd_count    = rd_count_q;
  assign drop_cnt    = drop_cnt_q;
  assign overflow    = overflow_q;
  assign dout        = FWFT ? dout_q : ram_rdata;

endmodule

// File: tb/tb_pkt_sfifo.sv
// Bench for pkt_sfifo: directed scenarios plus random traffic against a queue model.
module tb_pkt_sfifo;

  localparam int unsigned DW    = 18;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AFTH  = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wr_en = 1'b0, wr_commit = 1'b0, wr_abort = 1'b0;
  logic          rd_en0 = 1'b0, rd_en1 = 1'b0;

  logic          full0, af0, empty0, ovf0, full1, af1, empty1, ovf1;
  logic [DW-1:0] dout0, dout1;
  logic [AW:0]   cnt0, cnt1;
  logic [15:0]   drop0, drop1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model for the registered-read instance: committed and pending queues.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pkt[$];
  bit            m_drop;
  int            m_drops;
  logic [DW-1:0] m_dout;
  bit            m_ovf;

  always #5 clk = ~clk;

  pkt_sfifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_TH(AFTH), .FWFT(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_commit(wr_commit),
    .wr_abort(wr_abort), .full(full0), .almost_full(af0), .rd_en(rd_en0), .dout(dout0),
    .empty(empty0), .rd_count(cnt0), .drop_cnt(drop0), .overflow(ovf0)
  );

  pkt_sfifo #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALMOST_FULL_TH(AFTH), .FWFT(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .wr_commit(wr_commit),
    .wr_abort(wr_abort), .full(full1), .almost_full(af1), .rd_en(rd_en1), .dout(dout1),
    .empty(empty1), .rd_count(cnt1), .drop_cnt(drop1), .overflow(ovf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pkt.delete();
    m_drop  = 1'b0;
    m_drops = 0;
    m_dout  = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input logic we, input logic [DW-1:0] d, input logic cm,
                            input logic ab, input logic r0);
    bit fullp = ((m_q.size() + m_pkt.size()) == DEPTH);
    bit popd  = r0 && (m_q.size() != 0);
    bit endp  = cm || ab;
    m_ovf = 1'b0;
    if (popd) m_dout = m_q.pop_front();
    if (m_drop) begin
      if (endp) begin
        m_pkt.delete();
        if (m_drops < 65535) m_drops++;
        m_drop = 1'b0;
      end
    end else if (we && fullp) begin
      m_ovf = 1'b1;
      if (endp) begin
        m_pkt.delete();
        if (m_drops < 65535) m_drops++;
      end else begin
        m_drop = 1'b1;
      end
    end else begin
      if (we) m_pkt.push_back(d);
      if (ab) begin
        m_pkt.delete();
      end else if (cm) begin
        foreach (m_pkt[i]) m_q.push_back(m_pkt[i]);
        m_pkt.delete();
      end
    end
  endtask

  task automatic compare0();
    int total = m_q.size() + m_pkt.size();
    check_eq("empty", {31'd0, empty0}, {31'd0, m_q.size() == 0});
    check_eq("rd_count", {27'd0, cnt0}, m_q.size());
    check_eq("full", {31'd0, full0}, {31'd0, total == DEPTH});
    check_eq("almost_full", {31'd0, af0}, {31'd0, total >= AFTH});
    check_eq("overflow", {31'd0, ovf0}, {31'd0, m_ovf});
    check_eq("drop_cnt", {16'd0, drop0}, m_drops);
    check_eq("dout", {14'd0, dout0}, {14'd0, m_dout});
  endtask

  task automatic step(input logic we, input logic [DW-1:0] d, input logic cm, input logic ab,
                      input logic r0, input logic r1);
    wr_en = we; din = d; wr_commit = cm; wr_abort = ab; rd_en0 = r0; rd_en1 = r1;
    @(posedge clk);
    model_edge(we, d, cm, ab, r0);
    #1;
    compare0();
    wr_en = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0; rd_en0 = 1'b0; rd_en1 = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check_eq("rst_empty0", {31'd0, empty0}, 32'd1);
    check_eq("rst_full0", {31'd0, full0}, 32'd0);
    check_eq("rst_af0", {31'd0, af0}, 32'd0);
    check_eq("rst_cnt0", {27'd0, cnt0}, 32'd0);
    check_eq("rst_drop0", {16'd0, drop0}, 32'd0);
    check_eq("rst_ovf0", {31'd0, ovf0}, 32'd0);
    check_eq("rst_dout0", {14'd0, dout0}, 32'd0);
    check_eq("rst_empty1", {31'd0, empty1}, 32'd1);
    check_eq("rst_full1", {31'd0, full1}, 32'd0);
    check_eq("rst_cnt1", {27'd0, cnt1}, 32'd0);
    check_eq("rst_dout1", {14'd0, dout1}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int ovf_seen;
    int seq;
    int wp, rp;
    logic [DW-1:0] w [4];

    do_reset();

    // Five-word packet, then five registered reads.
    for (int i = 1; i <= 5; i++) step(1'b1, DW'(i), i == 5, 1'b0, 1'b0, 1'b0);
    check_eq("s1_count", {27'd0, cnt0}, 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("s1_last", {14'd0, dout0}, 32'h5);

    // Aborted packet followed by a two-word packet.
    for (int i = 0; i < 3; i++) step(1'b1, DW'(18'h10 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 18'h0AA, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 18'h0BB, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("s2_count", {27'd0, cnt0}, 32'd2);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("s2_last", {14'd0, dout0}, 32'h0BB);

    // Seventeen-word packet overflows a sixteen-word FIFO.
    ovf_seen = 0;
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, DW'(18'h100 + i), i == 17, 1'b0, 1'b0, 1'b0);
      if (ovf0) ovf_seen++;
      if (i == 16) check_eq("s3_full16", {31'd0, full0}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (ovf0) ovf_seen++;
    end
    check_eq("s3_ovf_pulses", ovf_seen, 32'd1);
    check_eq("s3_drop", {16'd0, drop0}, 32'd1);
    check_eq("s3_count", {27'd0, cnt0}, 32'd0);
    check_eq("s3_empty", {31'd0, empty0}, 32'd1);

    // Streaming across pointer wrap with continuous reads.
    seq = 18'h200;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'(seq), i == 9, 1'b0, 1'b0, 1'b0);
      seq++;
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) begin
        step(1'b1, DW'(seq), i == 15, 1'b0, 1'b1, 1'b0);
        seq++;
      end
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("s4_drained", {31'd0, empty0}, 32'd1);

    // Random traffic in phases of varying write/read pressure.
    for (int ph = 0; ph < 6; ph++) begin
      case (ph)
        0: begin wp = 80; rp = 20; end
        1: begin wp = 80; rp = 80; end
        2: begin wp = 30; rp = 90; end
        3: begin wp = 90; rp = 50; end
        4: begin wp = 95; rp = 5; end
        default: begin wp = 60; rp = 60; end
      endcase
      for (int i = 0; i < 250; i++) begin
        step($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < 12,
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < rp, 1'b0);
      end
    end

    // First-word-fall-through instance.
    do_reset();
    step(1'b1, 18'h3FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("fw_empty_e0", {31'd0, empty1}, 32'd1);
    check_eq("fw_count_e0", {27'd0, cnt1}, 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fw_empty_e1", {31'd0, empty1}, 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("fw_empty_e2", {31'd0, empty1}, 32'd0);
    check_eq("fw_dout_e2", {14'd0, dout1}, 32'h3FFFF);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("fw_empty_pop", {31'd0, empty1}, 32'd1);
    check_eq("fw_count_pop", {27'd0, cnt1}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      w[i] = DW'($urandom);
      step(1'b1, w[i], i == 3, 1'b0, 1'b0, 1'b0);
    end
    repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("fw_stream_empty", {31'd0, empty1}, 32'd0);
      check_eq("fw_stream_dout", {14'd0, dout1}, {14'd0, w[i]});
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("fw_stream_end", {31'd0, empty1}, 32'd1);

    // Reset mid-packet with committed data present.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, DW'(18'h300 + i), i == 3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, DW'(18'h310 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, DW'(18'h320 + i), i == 2, 1'b0, 1'b0, 1'b0);
    check_eq("rs_count", {27'd0, cnt0}, 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("rs_last", {14'd0, dout0}, 32'h322);
    check_eq("rs_empty", {31'd0, empty0}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
